or1k_store_buffer: RTL
======================

# or1k_store_buffer

Posted-write store buffer between the or1k load/store unit and the 32-bit Wishbone bus bridge CPU port. Stores are acknowledged to the LSU immediately and queued in a FIFO, then drained one classic single-beat write at a time. Loads pass through only when the buffer is empty, which preserves program order. Bus errors on drained stores are reported imprecisely on a dedicated pulse output.

## Interface
- DEPTH, 4, store FIFO entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- lsu_req_i  in  1  LSU access request, held until lsu_ack_o or lsu_err_o
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_adr_i  in  32  byte address
- lsu_dat_i  in  32  store data
- lsu_bsel_i  in  4  byte selects
- lsu_ack_o  out  1  access complete (store accepted / load data valid)
- lsu_err_o  out  1  load bus error
- lsu_dat_o  out  32  load data
- sb_empty_o  out  1  FIFO empty and no write in flight
- sb_full_o  out  1  FIFO holds DEPTH entries
- store_err_o  out  1  one-cycle pulse: drained store got bus error
- bus_req_o  out  1  request to bus bridge
- bus_we_o  out  1  write enable
- bus_adr_o  out  32  address
- bus_dat_o  out  32  write data
- bus_bsel_o  out  4  byte selects
- bus_burst_o  out  1  constant 0
- bus_ack_i  in  1  bridge ack
- bus_err_i  in  1  bridge error
- bus_dat_i  in  32  read data

## Operation
- Store push: lsu_req_i & lsu_we_i & !sb_full_o. Push {adr,dat,bsel}. lsu_ack_o=1 in the same cycle, combinationally. When full, lsu_ack_o=0 and the LSU stalls.
- FSM states are IDLE, WRITE, READ. The state is registered.
  - IDLE → WRITE when the FIFO is not empty. Drain has priority over loads.
  - IDLE → READ when the FIFO is empty & lsu_req_i & !lsu_we_i. On this transition, latch lsu_adr_i/lsu_bsel_i into load registers.
  - WRITE: bus_req_o=1, bus_we_o=1, bus_adr/dat/bsel driven from the FIFO head.
    - bus_ack_i: pop, → IDLE.
    - bus_err_i: pop, store_err_o=1 for one cycle, → IDLE. The entry is discarded and not retried.
  - READ: bus_req_o=1, bus_we_o=0, address/bsel taken from the load registers.
    - bus_ack_i: lsu_ack_o=1, lsu_dat_o=bus_dat_i, → IDLE.
    - bus_err_i: lsu_err_o=1, lsu_dat_o=0, → IDLE.
- IDLE drives bus_req_o=0 for at least one cycle between accesses.
- A simultaneous push and pop leaves the count unchanged. A push while full is impossible by construction.
- If bus_ack_i and bus_err_i are asserted together, err wins.
- Store-to-load forwarding is not implemented. A load always waits for sb_empty_o.
- Width rules:
  - Count is clog2(DEPTH)+1 bits.
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset values:
  - state IDLE; pointers and count 0.
  - Outputs: sb_empty_o=1 and bus_burst_o=0; every other output is 0, including lsu_dat_o.
- A reset mid-transaction discards all entries and any in-flight access.
- Store latency:
  - The ack is in the request cycle C.
  - bus_req_o first rises in cycle C+2, the earliest drain.
- Load latency with the buffer empty and the FSM idle:
  - Request in cycle C gives bus_req_o in cycle C+1.
  - lsu_ack_o comes in the same cycle as bus_ack_i.
- Back-to-back drains: each write occupies ≥2 cycles (WRITE ≥1, IDLE 1).
- bus_* outputs are stable while bus_req_o=1 and are driven only from registered state, FIFO storage, and the load registers.

## Structure
- Shared package holds the FSM state encoding (2 bits: IDLE=0, WRITE=1, READ=2) and a burst-off constant.
- Sub-module or1k_sync_fifo:
  - Generic synchronous FIFO, parameters WIDTH=68 and DEPTH.
  - Ports: push, pop, din, dout (head), full, empty, count.
  - The top level contains only the FSM, the load registers and the output muxing.

## Test plan
- Store to 0x100 (data 0xDEADBEEF, bsel 0xF), empty buffer: lsu_ack_o in C; bus write in C+2 at 0x100/0xDEADBEEF; sb_empty_o=1 after the ack.
- Five stores, DEPTH=4, bridge stalled: first four acked, fifth stalls (sb_full_o=1) until the first bus ack. The bus then writes all five in order.
- Two stores queued, then a load from 0x200: the bus issues both writes, then the read. lsu_ack_o with lsu_dat_o=bus_dat_i only after the writes complete.
- bus_err_i on the second of three drained stores: store_err_o pulses once, the third store is still written, and the buffer ends empty.
- Load from 0x300 answered with bus_err_i: lsu_err_o=1, lsu_dat_o=0, lsu_ack_o=0, FSM returns to IDLE.
- rst asserted during a WRITE with 3 entries queued: the next cycle shows bus_req_o=0, sb_empty_o=1, count 0, and no further bus writes.

Source files
------------

// File: rtl/or1k_store_buffer_pkg.sv
// Shared types for the or1k posted-write store buffer: FSM encoding and FIFO entry layout.
package or1k_store_buffer_pkg;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_WRITE = 2'd1,
    SB_READ  = 2'd2
  } sb_state_e;

  localparam logic BURST_OFF = 1'b0;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  bsel;
  } sb_entry_t;

  localparam int unsigned ENTRY_W = $bits(sb_entry_t);

endpackage

// File: rtl/or1k_sync_fifo.sv
// Generic synchronous FIFO; storage is not reset, only pointers and count are.
module or1k_sync_fifo #(
  parameter int unsigned WIDTH = 68,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/or1k_store_buffer.sv
// Posted-write store buffer between the LSU and the Wishbone bridge CPU port.
// Stores are acked at once and drained in order; loads wait until the buffer is empty.
module or1k_store_buffer
  import or1k_store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_adr_i,
  input  logic [31:0] lsu_dat_i,
  input  logic [3:0]  lsu_bsel_i,
  output logic        lsu_ack_o,
  output logic        lsu_err_o,
  output logic [31:0] lsu_dat_o,
  output logic        sb_empty_o,
  output logic        sb_full_o,
  output logic        store_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_bsel_o,
  output logic        bus_burst_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_dat_i
);

  sb_state_e                state_q, state_d;
  logic [31:0]              ld_adr_q, ld_adr_d;
  logic [3:0]               ld_bsel_q, ld_bsel_d;
  sb_entry_t                push_entry, head_entry;
  logic                     push, pop, rd_ack;
  logic                     fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count;

  assign push_entry = '{adr: lsu_adr_i, dat: lsu_dat_i, bsel: lsu_bsel_i};
  assign push       = lsu_req_i & lsu_we_i & ~fifo_full;

  or1k_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_entry),
    .dout_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= SB_IDLE;
    else     state_q <= state_d;
  end

  // Load address/bsel are data, captured only on the IDLE->READ transition.
  always_ff @(posedge clk) begin
    ld_adr_q  <= ld_adr_d;
    ld_bsel_q <= ld_bsel_d;
  end

  always_comb begin
    state_d     = state_q;
    ld_adr_d    = ld_adr_q;
    ld_bsel_d   = ld_bsel_q;
    pop         = 1'b0;
    rd_ack      = 1'b0;
    store_err_o = 1'b0;
    lsu_err_o   = 1'b0;
    lsu_dat_o   = '0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_adr_o   = '0;
    bus_dat_o   = '0;
    bus_bsel_o  = '0;
    unique case (state_q)
      SB_IDLE: begin
        if (!fifo_empty) begin
          state_d = SB_WRITE;
        end else if (lsu_req_i && !lsu_we_i) begin
          state_d   = SB_READ;
          ld_adr_d  = lsu_adr_i;
          ld_bsel_d = lsu_bsel_i;
        end
      end
      SB_WRITE: begin
        bus_req_o  = 1'b1;
        bus_we_o   = 1'b1;
        bus_adr_o  = head_entry.adr;
        bus_dat_o  = head_entry.dat;
        bus_bsel_o = head_entry.bsel;
        // An errored store is dropped, not retried.
        if (bus_err_i) begin
          pop         = 1'b1;
          store_err_o = 1'b1;
          state_d     = SB_IDLE;
        end else if (bus_ack_i) begin
          pop     = 1'b1;
          state_d = SB_IDLE;
        end
      end
      SB_READ: begin
        bus_req_o  = 1'b1;
        bus_adr_o  = ld_adr_q;
        bus_bsel_o = ld_bsel_q;
        if (bus_err_i) begin
          lsu_err_o = 1'b1;
          state_d   = SB_IDLE;
        end else if (bus_ack_i) begin
          rd_ack    = 1'b1;
          lsu_dat_o = bus_dat_i;
          state_d   = SB_IDLE;
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  assign lsu_ack_o   = push | rd_ack;
  assign sb_full_o   = fifo_full;
  assign sb_empty_o  = (fifo_count == '0) && (state_q != SB_WRITE);
  assign bus_burst_o = BURST_OFF;

endmodule
